// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver, transmitter and receive FIFO.
//   DEFAULT_DATA_BITS : default character width
//   RX_FLAG_BITS      : per-frame error flags stored with a character {parity, frame}
//   rx_entry_width()  : width of one buffered receive entry
package uart_pkg;

  localparam int unsigned DEFAULT_DATA_BITS = 8;
  localparam int unsigned RX_FLAG_BITS      = 2;

  function automatic int unsigned rx_entry_width(input int unsigned data_bits);
    return data_bits + RX_FLAG_BITS;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: WIDTH x DEPTH register array, one synchronous write port and
// one combinational read port. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data (combinational from raddr)
module uart_fifo_mem #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive buffer behind the UART receiver.
// Captures {parity_err, frame_err, rx_data} on each data_ready pulse and
// presents the head entry on a valid/ready stream. Frames arriving while full
// (and not being popped) are dropped and recorded in a sticky overrun flag plus
// a saturating 8-bit drop counter.
//   clk, reset_n        : clock, asynchronous active-low reset
//   rx_data, data_ready : character from receiver, one-cycle capture strobe
//   parity_err, frame_err : frame error flags, qualified by data_ready
//   flush               : synchronous clear of all entries (beats push/pop)
//   clear_overrun       : synchronous clear of overrun and overrun_count
//   m_data, m_parity_err, m_frame_err, m_valid, m_ready : head-entry stream
//   count, full, empty  : occupancy
//   overrun, overrun_count : drop reporting
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = DEFAULT_DATA_BITS,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_BITS-1:0]   rx_data,
  input  logic                   data_ready,
  input  logic                   parity_err,
  input  logic                   frame_err,
  input  logic                   flush,
  input  logic                   clear_overrun,
  output logic [DATA_BITS-1:0]   m_data,
  output logic                   m_parity_err,
  output logic                   m_frame_err,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overrun,
  output logic [7:0]             overrun_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = rx_entry_width(DATA_BITS);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    ovr_cnt_q, ovr_cnt_d;

  logic          pop;
  logic          push_ok;
  logic          drop;
  logic          mem_we;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign m_valid = !empty;

  assign pop     = m_valid & m_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO succeeds.
  assign push_ok = data_ready & (!full | pop);
  // Flush discards the incoming frame outright; it is not treated as a drop.
  assign drop    = data_ready & full & !pop & !flush;
  assign mem_we  = push_ok & !flush;

  assign wr_entry = {parity_err, frame_err, rx_data};

  uart_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  assign m_parity_err = rd_entry[EW-1];
  assign m_frame_err  = rd_entry[EW-2];
  assign m_data       = rd_entry[DATA_BITS-1:0];

  assign count         = count_q;
  assign overrun       = overrun_q;
  assign overrun_count = ovr_cnt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    ovr_cnt_d = ovr_cnt_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // A drop coinciding with clear_overrun restarts the count at one.
    if (drop) begin
      overrun_d = 1'b1;
      if (clear_overrun)          ovr_cnt_d = 8'd1;
      else if (ovr_cnt_q != '1)   ovr_cnt_d = ovr_cnt_q + 8'd1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
      ovr_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo (DATA_BITS=8, DEPTH=16).
// A queue-based reference model tracks stored frames and overrun status;
// directed sequences are followed by randomized traffic.
module tb_uart_rx_fifo;

  localparam int unsigned DB  = 8;
  localparam int unsigned DEP = 16;

  logic          clk;
  logic          reset_n;
  logic [DB-1:0] rx_data;
  logic          data_ready;
  logic          parity_err;
  logic          frame_err;
  logic          flush;
  logic          clear_overrun;
  logic [DB-1:0] m_data;
  logic          m_parity_err;
  logic          m_frame_err;
  logic          m_valid;
  logic          m_ready;
  logic [4:0]    count;
  logic          full;
  logic          empty;
  logic          overrun;
  logic [7:0]    overrun_count;

  uart_rx_fifo #(
    .DATA_BITS (DB),
    .DEPTH     (DEP)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .flush         (flush),
    .clear_overrun (clear_overrun),
    .m_data        (m_data),
    .m_parity_err  (m_parity_err),
    .m_frame_err   (m_frame_err),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .overrun       (overrun),
    .overrun_count (overrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each entry is {parity, frame, data}.
  logic [DB+1:0] mq[$];
  bit            m_ovr;
  int unsigned   m_ovr_cnt;

  int unsigned nvec;
  int unsigned nerr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ":count"},   32'(count),         32'(mq.size()));
    check_eq({tag, ":full"},    32'(full),          32'(mq.size() == DEP));
    check_eq({tag, ":empty"},   32'(empty),         32'(mq.size() == 0));
    check_eq({tag, ":m_valid"}, 32'(m_valid),       32'(mq.size() != 0));
    check_eq({tag, ":overrun"}, 32'(overrun),       32'(m_ovr));
    check_eq({tag, ":ovr_cnt"}, 32'(overrun_count), m_ovr_cnt);
    if (mq.size() != 0) begin
      check_eq({tag, ":m_data"}, 32'(m_data),       32'(mq[0][DB-1:0]));
      check_eq({tag, ":m_perr"}, 32'(m_parity_err), 32'(mq[0][DB+1]));
      check_eq({tag, ":m_ferr"}, 32'(m_frame_err),  32'(mq[0][DB]));
    end
  endtask

  // Apply one cycle of inputs, advance the model by the same rules, then compare.
  task automatic step(input string tag, input bit dr, input logic [DB-1:0] d,
                      input bit pe, input bit fe, input bit rdy,
                      input bit fl, input bit clr);
    bit dropped;
    rx_data = d; data_ready = dr; parity_err = pe; frame_err = fe;
    m_ready = rdy; flush = fl; clear_overrun = clr;
    dropped = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (dr) begin
        if (mq.size() < DEP) mq.push_back({pe, fe, d});
        else dropped = 1'b1;
      end
    end
    if (dropped) begin
      m_ovr     = 1'b1;
      m_ovr_cnt = clr ? 1 : ((m_ovr_cnt < 255) ? m_ovr_cnt + 1 : 255);
    end else if (clr) begin
      m_ovr     = 1'b0;
      m_ovr_cnt = 0;
    end
    @(posedge clk);
    #1;
    data_ready = 1'b0; m_ready = 1'b0; flush = 1'b0; clear_overrun = 1'b0;
    check_all(tag);
  endtask

  task automatic push(input string tag, input logic [DB-1:0] d, input bit pe, input bit fe);
    step(tag, 1'b1, d, pe, fe, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_one(input string tag, input logic [DB-1:0] exp_d);
    check_eq({tag, ":head"}, 32'(m_data), 32'(exp_d));
    step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovr     = 1'b0;
    m_ovr_cnt = 0;
  endtask

  initial begin
    nvec = 0; nerr = 0;
    reset_n = 1'b0;
    rx_data = '0; data_ready = 1'b0; parity_err = 1'b0; frame_err = 1'b0;
    flush = 1'b0; clear_overrun = 1'b0; m_ready = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic ordering with stalled consumer.
    push("p41", 8'h41, 1'b0, 1'b0);
    push("p42", 8'h42, 1'b0, 1'b0);
    push("p43", 8'h43, 1'b0, 1'b0);
    check_eq("tp1:count", 32'(count), 32'd3);
    check_eq("tp1:head",  32'(m_data), 32'h41);
    pop_one("r41", 8'h41);
    pop_one("r42", 8'h42);
    pop_one("r43", 8'h43);
    check_eq("tp1:empty", 32'(empty), 32'd1);

    // Error flags travel with their own entries.
    push("p55", 8'h55, 1'b1, 1'b0);
    push("p66", 8'h66, 1'b0, 1'b1);
    check_eq("tp2:perr55", 32'(m_parity_err), 32'd1);
    check_eq("tp2:ferr55", 32'(m_frame_err),  32'd0);
    pop_one("r55", 8'h55);
    check_eq("tp2:perr66", 32'(m_parity_err), 32'd0);
    check_eq("tp2:ferr66", 32'(m_frame_err),  32'd1);
    pop_one("r66", 8'h66);

    // Fill, overflow twice, drain, clear.
    for (int i = 0; i < 16; i++) push("fill", 8'(i), 1'b0, 1'b0);
    push("ovfAA", 8'hAA, 1'b0, 1'b0);
    push("ovfBB", 8'hBB, 1'b0, 1'b0);
    check_eq("tp3:full",    32'(full),          32'd1);
    check_eq("tp3:ovr",     32'(overrun),       32'd1);
    check_eq("tp3:ovr_cnt", 32'(overrun_count), 32'd2);
    for (int i = 0; i < 16; i++) pop_one("drain", 8'(i));
    step("clr", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("tp3:ovr_clr", 32'(overrun_count), 32'd0);

    // Push and pop together at full.
    for (int i = 0; i < 16; i++) push("fill2", 8'(8'h20 + i), 1'b0, 1'b0);
    step("pp_full", 1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("tp4:count", 32'(count),   32'd16);
    check_eq("tp4:ovr",   32'(overrun), 32'd0);
    for (int i = 1; i < 16; i++) pop_one("drain2", 8'(8'h20 + i));
    pop_one("last99", 8'h99);

    // Streaming through two pointer wraps.
    for (int i = 0; i < 40; i++) begin
      step("stream", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("tp5:count_le1", 32'(count <= 5'd1), 32'd1);
    end
    pop_one("stream_last", 8'(8'h80 + 39));

    // Drop coinciding with clear_overrun.
    for (int i = 0; i < 16; i++) push("fill3", 8'(i * 3), 1'b0, 1'b0);
    push("ovf3a", 8'hC1, 1'b0, 1'b0);
    push("ovf3b", 8'hC2, 1'b0, 1'b0);
    step("drop_clr", 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("drop_clr:cnt", 32'(overrun_count), 32'd1);
    step("clr2", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Flush wins over an arriving frame; also flush while full doesn't count a drop.
    step("fl_full", 1'b1, 8'hDD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) push("fill5", 8'(8'h70 + i), 1'b1, 1'b0);
    step("flush", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("tp6:count", 32'(count),   32'd0);
    check_eq("tp6:valid", 32'(m_valid), 32'd0);
    check_eq("tp6:ovr",   32'(overrun), 32'd0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 4; i++) push("pre_rst", 8'(8'h30 + i), 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    #3;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_rst");

    // Randomized traffic: balanced, then producer-heavy to exercise overflow.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        bit dr, rdy, fl, clr;
        dr  = ($urandom_range(99) < (ph == 0 ? 50 : 80));
        rdy = ($urandom_range(99) < (ph == 0 ? 55 : 20));
        fl  = ($urandom_range(199) == 0);
        clr = ($urandom_range(59) == 0);
        step("rand", dr, 8'($urandom), 1'($urandom), 1'($urandom), rdy, fl, clr);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Captures each received frame (data plus parity/frame error flags) on the receiver's data_ready pulse.
- Stores frames in a first-word-fall-through FIFO and presents them to the consumer over a valid/ready stream.
- Reports occupancy, drops frames on overflow, and flags overruns so no frame is lost silently.

Parameters:
DATA_BITS, 8, width of one received character; must match the receiver's DATA_BITS (1..15)
DEPTH, 16, number of entries; power of two, 2..256

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
rx_data  input  DATA_BITS  character from receiver, valid when data_ready=1
data_ready  input  1  one-cycle pulse per received frame
parity_err  input  1  parity error flag for the frame, qualified by data_ready
frame_err  input  1  stop-bit error flag for the frame, qualified by data_ready
flush  input  1  synchronous clear of all entries
clear_overrun  input  1  synchronous clear of the overrun flag and counter
m_data  output  DATA_BITS  head-entry character
m_parity_err  output  1  head-entry parity error flag
m_frame_err  output  1  head-entry frame error flag
m_valid  output  1  head entry present (equals !empty)
m_ready  input  1  consumer accepts head entry when m_valid & m_ready
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
full  output  1  count==DEPTH
empty  output  1  count==0
overrun  output  1  sticky; set when a frame is dropped
overrun_count  output  8  saturating count of dropped frames

Behaviour:
- Reset (reset_n=0, asynchronous): rd_ptr=wr_ptr=0; count=0; empty=1; full=0; m_valid=0; overrun=0; overrun_count=0. m_data and the flag outputs read whatever is at memory index 0; memory contents are not reset. Memory contents are don't-care while empty.
- Entry: {parity_err, frame_err, rx_data}, width DATA_BITS+2, captured on the clk edge where data_ready=1.
- pop = m_valid & m_ready.
- push_ok = data_ready & (!full | pop).
  - Pop and push in the same cycle while full: both happen; count stays DEPTH.
- Push while full with no pop: frame is dropped; memory and pointers are unchanged.
  - Next cycle: overrun=1.
  - overrun_count increments and saturates at 255.
- Latency: push at edge N gives m_valid=1 with the new head after edge N (first word fall through, read is a combinational mux of the register array).
- Pop: head advances on the edge. The next entry, or m_valid=0, is visible after that edge.
- Simultaneous push and pop while empty: pop is not possible because m_valid=0. Push proceeds normally.
- Simultaneous push and pop, otherwise: count unchanged, both pointers advance.
- Pointers: $clog2(DEPTH) bits and wrap naturally modulo DEPTH. count is tracked separately so full and empty are unambiguous.
- flush: priority over push and pop in the same cycle.
  - Pointers go to 0, count to 0, m_valid to 0.
  - A data_ready arriving in the flush cycle is discarded and does not count as an overrun.
- clear_overrun: clears overrun and overrun_count next cycle. If a drop occurs in the same cycle, the drop wins: overrun=1, overrun_count=1.
- Error flags are stored and forwarded unchanged. Frames with errors are buffered like any other frame.
- m_data, flags and m_valid are stable while m_valid=1 and m_ready=0.
- No internal state machine beyond pointer and count control. All control is registered; outputs are functions of registers only (no combinational path from data_ready to m_valid).

Decomposition:
- uart_pkg holds the following, shared with the receiver and transmitter:
  - localparam DEFAULT_DATA_BITS=8
  - localparam RX_FLAG_BITS=2
  - helper function for the entry width
- One sub-module, uart_fifo_mem:
  - parameterised WIDTH and DEPTH register array
  - single write port (we, waddr, wdata)
  - combinational read port (raddr, rdata)
- Pointer, count and overrun logic stays in uart_rx_fifo.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 with m_ready=0 -> count=3, m_valid=1, m_data=0x41; raise m_ready for 3 cycles -> 0x41, 0x42, 0x43 in order, then empty=1, m_valid=0.
- Push 0x55 with parity_err=1 and 0x66 with frame_err=1 -> both delivered, flags on the matching entries only (0x55: m_parity_err=1, m_frame_err=0; 0x66: 0, 1).
- Fill 16 entries (0x00..0x0F), push 0xAA and 0xBB -> full=1, overrun=1, overrun_count=2; drain yields 0x00..0x0F only; clear_overrun -> overrun=0, overrun_count=0.
- At full, push 0x99 in the same cycle as a pop -> count stays 16, last entry read is 0x99, overrun stays 0.
- Write 40 frames with continuous m_ready=1 (pointer wrap twice) -> all 40 values received in order, count never exceeds 1.
- Buffer 5 entries, assert flush together with data_ready -> count=0, m_valid=0, overrun=0; assert reset_n=0 mid-stream -> all outputs at reset values immediately, without waiting for a clk edge.
